// File: rtl/fifo_sc_gen_if.sv
// fifo_sc_gen_if -- handshake/data bundle for fifo_sc_gen.
//   master : drives write/read requests, write data and error clear
//   slave  : the FIFO; drives read data, valid, occupancy, status and error flags
interface fifo_sc_gen_if #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                  i_trg_wr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_trg_rd;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_vld;
  logic [ADDR_WIDTH:0]   o_used;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_a_full;
  logic                  o_a_empty;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_trg_wr, i_data, i_trg_rd, i_clr_err,
    input  o_data, o_data_vld, o_used, o_full, o_empty, o_a_full, o_a_empty,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_trg_wr, i_data, i_trg_rd, i_clr_err,
    output o_data, o_data_vld, o_used, o_full, o_empty, o_a_full, o_a_empty,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sc_gen.sv
// fifo_sc_gen -- single-clock synchronous FIFO on an inferred dual-port RAM.
//   i_clk      : clock, rising edge
//   i_rst_sync : asynchronous active-high reset (pointers, counts, flags, output)
//   bus        : fifo_sc_gen_if.slave -- write/read requests, data, occupancy,
//                full/empty/almost flags, sticky overflow/underflow
// FWFT = 0 : registered read, o_data_vld pulses one cycle after an accepted read.
// FWFT = 1 : first-word-fall-through through a one-word output register that is
//            counted as storage (total capacity DEPTH).
module fifo_sc_gen #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned A_FULL     = 2,
  parameter int unsigned A_EMPTY    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_sync,
  fifo_sc_gen_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_LVL  = cnt_t'(DEPTH - A_FULL);
  localparam cnt_t AE_LVL  = cnt_t'(A_EMPTY);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  cnt_t                  ram_cnt_q, ram_cnt_d;
  cnt_t                  used_q, used_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  a_full_q, a_full_d;
  logic                  a_empty_q, a_empty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc;
  logic                  pop;
  logic                  ram_rd;

  always_comb begin
    wr_acc    = bus.i_trg_wr && !full_q;
    // empty_q already reflects the output register in FWFT mode, so the same
    // acceptance test serves both read modes.
    pop       = bus.i_trg_rd && !empty_q;
    ram_rd    = pop;
    vld_d     = pop;
    data_d    = data_q;

    if (FWFT != 0) begin
      // Refill the output register whenever it is free or being vacated.
      ram_rd = (ram_cnt_q != '0) && (!vld_q || pop);
      vld_d  = ram_rd || (vld_q && !pop);
    end

    if (ram_rd) begin
      data_d = mem_q[rd_ptr_q];
    end

    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(ram_rd);

    ram_cnt_d = ram_cnt_q;
    case ({wr_acc, ram_rd})
      2'b10:   ram_cnt_d = ram_cnt_q + cnt_t'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - cnt_t'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    used_d = ram_cnt_d;
    if (FWFT != 0) begin
      used_d = ram_cnt_d + cnt_t'(vld_d);
    end

    full_d    = (used_d >= DEPTH_C);
    empty_d   = (FWFT != 0) ? !vld_d : (used_d == '0);
    a_full_d  = (used_d >= AF_LVL);
    a_empty_d = (used_d <= AE_LVL);

    // Setting takes priority over a simultaneous clear.
    ovf_d = ovf_q;
    if (bus.i_clr_err) ovf_d = 1'b0;
    if (bus.i_trg_wr && full_q) ovf_d = 1'b1;

    udf_d = udf_q;
    if (bus.i_clr_err) udf_d = 1'b0;
    if (bus.i_trg_rd && empty_q) udf_d = 1'b1;
  end

  // Storage array: not reset, unreachable after reset via pointer/count clear.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_sync) begin
    if (i_rst_sync) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      used_q    <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      a_full_q  <= 1'b0;
      a_empty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      used_q    <= used_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      a_full_q  <= a_full_d;
      a_empty_q <= a_empty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_data_vld  = vld_q;
  assign bus.o_used      = used_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_a_full    = a_full_q;
  assign bus.o_a_empty   = a_empty_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
endmodule
